// File: rtl/digital_lock_seq.sv
// Multi-digit code lock: keypad digit entry, attempt counting with timed lockout,
// a timed unlock window, and reprogramming of the stored code while unlocked.
module digital_lock_seq #(
    parameter int unsigned DIGIT_W = 4,
    parameter int unsigned CODE_LEN = 4,
    parameter logic [CODE_LEN*DIGIT_W-1:0] DEFAULT_CODE = 16'h1234,
    parameter int unsigned MAX_ATTEMPTS = 3,
    parameter int unsigned LOCKOUT_CYCLES = 10,
    parameter int unsigned UNLOCK_CYCLES = 5
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                digit_valid,
    input  logic [DIGIT_W-1:0]                  digit,
    input  logic                                enter,
    input  logic                                clear,
    input  logic                                prog_req,
    output logic                                unlock_led,
    output logic                                error_led,
    output logic                                lockout_led,
    output logic [$clog2(MAX_ATTEMPTS+1)-1:0]   attempts_left
);

    localparam int unsigned CODE_W  = CODE_LEN * DIGIT_W;
    localparam int unsigned CNT_W   = $clog2(CODE_LEN + 1);
    localparam int unsigned ATT_W   = $clog2(MAX_ATTEMPTS + 1);
    localparam int unsigned TMR_MAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [1:0] {
        ST_ENTRY    = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_PROG     = 2'd2,
        ST_LOCKOUT  = 2'd3
    } state_e;

    state_e              state_q;
    logic [CODE_W-1:0]   buf_q;
    logic [CODE_W-1:0]   code_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [TMR_W-1:0]    tmr_q;
    logic [ATT_W-1:0]    att_q;
    logic                enter_q;
    logic                unlock_q;
    logic                error_q;
    logic                lockout_q;

    logic                enter_edge_c;
    logic                buf_full_c;
    logic                code_match_c;
    logic                last_try_c;
    logic                unlock_done_c;
    logic                lockout_done_c;
    logic [CODE_W-1:0]   buf_shift_c;

    // Decode helpers; the newest digit always lands in the least significant slot
    assign enter_edge_c   = enter & ~enter_q;
    assign buf_full_c     = (cnt_q == CNT_W'(CODE_LEN));
    assign code_match_c   = buf_full_c && (buf_q == code_q);
    assign last_try_c     = (att_q == ATT_W'(1));
    assign unlock_done_c  = (tmr_q == TMR_W'(UNLOCK_CYCLES - 1));
    assign lockout_done_c = (tmr_q == TMR_W'(LOCKOUT_CYCLES - 1));
    assign buf_shift_c    = (buf_q << DIGIT_W) | CODE_W'(digit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_ENTRY;
            buf_q     <= '0;
            cnt_q     <= '0;
            code_q    <= DEFAULT_CODE;
            tmr_q     <= '0;
            att_q     <= ATT_W'(MAX_ATTEMPTS);
            enter_q   <= 1'b0;
            unlock_q  <= 1'b0;
            error_q   <= 1'b0;
            lockout_q <= 1'b0;
        end else begin
            // Edge history tracks every cycle so a held enter never fires after a state change
            enter_q <= enter;
            case (state_q)
                ST_ENTRY: begin
                    if (clear) begin
                        buf_q <= '0;
                        cnt_q <= '0;
                    end else if (enter_edge_c) begin
                        buf_q <= '0;
                        cnt_q <= '0;
                        if (code_match_c) begin
                            state_q  <= ST_UNLOCKED;
                            unlock_q <= 1'b1;
                            error_q  <= 1'b0;
                            att_q    <= ATT_W'(MAX_ATTEMPTS);
                            tmr_q    <= '0;
                        end else if (last_try_c) begin
                            state_q   <= ST_LOCKOUT;
                            lockout_q <= 1'b1;
                            error_q   <= 1'b0;
                            att_q     <= '0;
                            tmr_q     <= '0;
                        end else begin
                            error_q <= 1'b1;
                            att_q   <= att_q - ATT_W'(1);
                        end
                    end else if (digit_valid && !buf_full_c) begin
                        buf_q   <= buf_shift_c;
                        cnt_q   <= cnt_q + CNT_W'(1);
                        error_q <= 1'b0;
                    end
                end

                ST_UNLOCKED: begin
                    if (prog_req) begin
                        state_q <= ST_PROG;
                        buf_q   <= '0;
                        cnt_q   <= '0;
                        tmr_q   <= '0;
                    end else if (unlock_done_c) begin
                        state_q  <= ST_ENTRY;
                        unlock_q <= 1'b0;
                        tmr_q    <= '0;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end

                ST_PROG: begin
                    if (clear) begin
                        state_q  <= ST_ENTRY;
                        unlock_q <= 1'b0;
                        buf_q    <= '0;
                        cnt_q    <= '0;
                    end else if (enter_edge_c) begin
                        // A short entry leaves the old code in place and flags the error
                        if (buf_full_c) begin
                            code_q <= buf_q;
                        end else begin
                            error_q <= 1'b1;
                        end
                        state_q  <= ST_ENTRY;
                        unlock_q <= 1'b0;
                        buf_q    <= '0;
                        cnt_q    <= '0;
                    end else if (digit_valid && !buf_full_c) begin
                        buf_q <= buf_shift_c;
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                ST_LOCKOUT: begin
                    if (lockout_done_c) begin
                        state_q   <= ST_ENTRY;
                        lockout_q <= 1'b0;
                        att_q     <= ATT_W'(MAX_ATTEMPTS);
                        tmr_q     <= '0;
                    end else begin
                        tmr_q <= tmr_q + TMR_W'(1);
                    end
                end

                default: begin
                    state_q <= ST_ENTRY;
                end
            endcase
        end
    end

    assign unlock_led    = unlock_q;
    assign error_led     = error_q;
    assign lockout_led   = lockout_q;
    assign attempts_left = att_q;

endmodule

// File: doc/digital_lock_seq.md
# digital_lock_seq

Parametrised multi-digit code lock. It sits between the keypad front end and the status LEDs, replacing the single-word lock. Digits are entered one per strobe and compared on a rising edge of `enter`. The block counts failures, enforces a timed lockout, holds unlock for a fixed window, and lets the user reprogram the code while unlocked.

## Interface
- `DIGIT_W`, 4: bits per digit.
- `CODE_LEN`, 4: digits per code.
- `DEFAULT_CODE`, 16'h1234: code loaded at reset, CODE_LEN*DIGIT_W bits. The first-entered digit occupies the MSBs.
- `MAX_ATTEMPTS`, 3: consecutive failures that trigger lockout (≥1).
- `LOCKOUT_CYCLES`, 10: lockout duration in clk cycles (≥1).
- `UNLOCK_CYCLES`, 5: unlock window in clk cycles (≥1).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `digit_valid`  in  1  one digit is accepted in each cycle this is high.
- `digit`  in  DIGIT_W  digit value, sampled when `digit_valid`=1.
- `enter`  in  1  level input; the block detects its rising edge internally.
- `clear`  in  1  discards partial entry.
- `prog_req`  in  1  requests code programming (valid only in UNLOCKED).
- `unlock_led`  out  1  high in UNLOCKED and PROG.
- `error_led`  out  1  last submission failed.
- `lockout_led`  out  1  high in LOCKOUT.
- `attempts_left`  out  $clog2(MAX_ATTEMPTS+1)  failures remaining before lockout.

## Operation
- States:
  - ENTRY (reset state)
  - UNLOCKED
  - PROG
  - LOCKOUT
- Entry buffer: shift register of CODE_LEN digits plus a digit count `cnt` (0..CODE_LEN). Each accepted digit shifts in at the LSB end and increments `cnt`. Once `cnt`=CODE_LEN, further digits are ignored (no shift, count saturates).
- Enter edge: `enter`=1 this cycle and `enter_q`=0. `enter_q` updates every cycle in every state, so an `enter` held through lockout does not fire on exit.
- Priority within a cycle: `clear` > enter edge > `digit_valid`. A digit that arrives in the same cycle as an enter edge is discarded.
- ENTRY, enter edge:
  - Match requires `cnt`=CODE_LEN and buffer == stored code.
  - On match: go to UNLOCKED, `error_led`←0, `attempts_left`←MAX_ATTEMPTS.
  - On mismatch or short entry: `error_led`←1 and `attempts_left` decrements. If it reaches 0, go to LOCKOUT with `error_led`←0.
  - Either way, the buffer is cleared.
- ENTRY, first accepted digit after a failure clears `error_led`. `clear` empties the buffer and leaves `error_led` unchanged.
- UNLOCKED: a timer runs for UNLOCK_CYCLES, then the block returns to ENTRY. Digits and enter are ignored. `prog_req`=1 moves to PROG and clears the buffer; if it coincides with the final timer cycle, `prog_req` wins.
- PROG: there is no timeout. Digits fill the buffer.
  - Enter edge with `cnt`=CODE_LEN: stored code ← buffer, go to ENTRY.
  - Enter edge with `cnt`<CODE_LEN: code unchanged, `error_led`←1, go to ENTRY; `attempts_left` is not decremented.
  - `clear`: abort to ENTRY with code unchanged.
- LOCKOUT: all inputs are ignored. After LOCKOUT_CYCLES the block goes to ENTRY, `attempts_left`←MAX_ATTEMPTS and `lockout_led`←0.
- Reset (async, any time, including mid-entry or mid-lockout):
  - State ENTRY, buffer and `cnt` cleared, `enter_q`←0.
  - Stored code ← DEFAULT_CODE.
  - All LEDs 0, `attempts_left`=MAX_ATTEMPTS, timers 0.

## Timing
- All outputs are registered and have no combinational input-to-output path.
- An enter edge sampled at clock edge N changes outputs after edge N; they are visible in cycle N+1.
- `unlock_led` is high for exactly UNLOCK_CYCLES cycles after a successful check, unless PROG is entered.
- `lockout_led` is high for exactly LOCKOUT_CYCLES cycles.
- A digit can be accepted every cycle (one digit per cycle); there is no backpressure.
- Timers are $clog2(max+1) bits wide and never wrap. `attempts_left` never underflows.

## Test plan
- Reset, then digits 1,2,3,4 on consecutive cycles, then an enter edge → `unlock_led`=1 the next cycle for 5 cycles, then 0. `attempts_left`=3 throughout.
- Wrong code 1,2,3,5 plus enter, three times → `error_led`=1 with `attempts_left` 2 then 1. The third failure sets `lockout_led`=1 for 10 cycles with `error_led`=0. Digits and enter during lockout are ignored. On exit, `attempts_left`=3.
- Three digits then enter → counted as a failure (`attempts_left`=2). Five digits 1,2,3,4,9 then enter → unlock (the fifth digit is ignored).
- Unlock, raise `prog_req`, enter 9,8,7,6 plus enter → return to ENTRY. Then 1,2,3,4 plus enter fails, and 9,8,7,6 plus enter unlocks. Reset restores code 1234.
- `enter` held high across lockout exit → no submission. `digit_valid` in the same cycle as an enter edge → digit dropped. `clear` in the same cycle as an enter edge → no submission.
- Assert `rst_n`=0 mid-lockout and mid-PROG → all LEDs 0 immediately (async), `attempts_left`=3, code 1234.
